// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared Hamming code geometry and position helpers
package hamming_pkg;

  // Smallest P with 2^P >= data_w + P + 1.
  function automatic int calc_p(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < (data_w + p + 1)) p = p + 1;
    return p;
  endfunction

  function automatic int calc_n(input int data_w);
    return data_w + calc_p(data_w);
  endfunction

  function automatic int calc_cw(input int data_w, input int secded);
    return calc_n(data_w) + ((secded != 0) ? 1 : 0);
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Codeword position (1-based) that carries payload bit j.
  function automatic int data_pos(input int j);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int pos = 1; pos < 128; pos++) begin
      if (!is_pow2(pos) && (res == 0)) begin
        if (cnt == j) res = pos;
        cnt = cnt + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// rtl/hamming_syndrome.sv - combinational position-XOR syndrome and overall parity
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int N  = 7,
  parameter int P  = 3,
  parameter int CW = 8
) (
  input  logic [CW-1:0] i_word,
  output logic [P-1:0]  o_syndrome,
  output logic          o_parity
);

  always_comb begin
    o_syndrome = '0;
    for (int pos = 1; pos <= N; pos++) begin
      if (i_word[pos-1]) o_syndrome = o_syndrome ^ P'(pos);
    end
    o_parity = ^i_word;
  end

endmodule

// File: rtl/hamming_secded_codec.sv
// rtl/hamming_secded_codec.sv - two-stage pipelined Hamming SEC/SEC-DED encoder/decoder
module hamming_secded_codec
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int SECDED = 1,
  parameter int CNT_W  = 16,
  localparam int P  = calc_p(DATA_W),
  localparam int N  = calc_n(DATA_W),
  localparam int CW = calc_cw(DATA_W, SECDED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_data,
  output logic [P-1:0]     out_syndrome,
  output logic             out_err_single,
  output logic             out_err_double,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_corrected,
  output logic [CNT_W-1:0] cnt_uncorrectable
);

  localparam logic [P-1:0] N_P = P'(N);

  logic              r1_valid, r1_mode, r1_par;
  logic [CW-1:0]     r1_word;
  logic [P-1:0]      r1_syn;
  logic              r2_valid, r2_single, r2_double;
  logic [CW-1:0]     r2_data;
  logic [P-1:0]      r2_syn;
  logic [CNT_W-1:0]  r_cnt_corr, r_cnt_unc;

  logic              w_s2_ready, w_in_ready, w_fire;
  logic [CW-1:0]     w_placed, w_s1_word, w_enc, w_corr, w_dec;
  logic [DATA_W-1:0] w_payload;
  logic [P-1:0]      w_syn;
  logic              w_par, w_perr, w_fix, w_single, w_double;

  // Payload scatter for encode and gather after correction share one position map.
  for (genvar j = 0; j < DATA_W; j++) begin : g_data
    localparam int POS = data_pos(j);
    assign w_placed[POS-1] = in_data[j];
    assign w_payload[j]    = w_corr[POS-1];
  end
  for (genvar pos = 1; pos <= CW; pos++) begin : g_zero
    if (is_pow2(pos) || (pos > N)) begin : g_z
      assign w_placed[pos-1] = 1'b0;
    end
  end

  assign w_s1_word = mode ? in_data : w_placed;

  // Encode reuses the syndrome: with parity slots zeroed, syndrome bit k is p(2^k).
  hamming_syndrome #(.N(N), .P(P), .CW(CW)) u_syndrome (
    .i_word     (w_s1_word),
    .o_syndrome (w_syn),
    .o_parity   (w_par)
  );

  assign w_s2_ready = !r2_valid || out_ready;
  assign w_in_ready = !rst && (!r1_valid || w_s2_ready);
  assign w_fire     = r2_valid && out_ready;

  always_comb begin
    w_enc = r1_word;
    for (int k = 0; k < P; k++) w_enc[(1 << k) - 1] = r1_syn[k];
    if (SECDED != 0) w_enc[CW-1] = r1_par ^ (^r1_syn);
  end

  always_comb begin
    w_fix    = 1'b0;
    w_single = 1'b0;
    w_double = 1'b0;
    w_perr   = (SECDED != 0) ? r1_par : 1'b0;
    if (r1_syn > N_P) begin
      w_double = 1'b1;
    end else if (SECDED != 0) begin
      if ((r1_syn != '0) && w_perr) begin
        w_fix    = 1'b1;
        w_single = 1'b1;
      end else if (w_perr) begin
        w_single = 1'b1;
      end else if (r1_syn != '0) begin
        w_double = 1'b1;
      end
    end else if (r1_syn != '0) begin
      w_fix    = 1'b1;
      w_single = 1'b1;
    end
    w_corr = r1_word ^ (w_fix ? (CW'(1) << (r1_syn - 1'b1)) : '0);
    w_dec  = CW'(w_payload);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_mode  <= 1'b0;
      r1_par   <= 1'b0;
      r1_word  <= '0;
      r1_syn   <= '0;
    end else if (w_in_ready) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_mode <= mode;
        r1_word <= w_s1_word;
        r1_syn  <= w_syn;
        r1_par  <= w_par;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_valid  <= 1'b0;
      r2_data   <= '0;
      r2_syn    <= '0;
      r2_single <= 1'b0;
      r2_double <= 1'b0;
    end else if (w_s2_ready) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_data   <= r1_mode ? w_dec : w_enc;
        r2_syn    <= r1_mode ? r1_syn : '0;
        r2_single <= r1_mode && w_single;
        r2_double <= r1_mode && w_double;
      end
    end
  end

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_corr <= '0;
      r_cnt_unc  <= '0;
    end else if (cnt_clr) begin
      r_cnt_corr <= '0;
      r_cnt_unc  <= '0;
    end else if (w_fire) begin
      if (r2_single && (r_cnt_corr != '1)) r_cnt_corr <= r_cnt_corr + 1'b1;
      if (r2_double && (r_cnt_unc != '1))  r_cnt_unc  <= r_cnt_unc + 1'b1;
    end
  end

  assign in_ready          = w_in_ready;
  assign out_valid         = r2_valid;
  assign out_data          = r2_data;
  assign out_syndrome      = r2_syn;
  assign out_err_single    = r2_single;
  assign out_err_double    = r2_double;
  assign cnt_corrected     = r_cnt_corr;
  assign cnt_uncorrectable = r_cnt_unc;

endmodule

// File: tb/tb_hamming_secded_codec.sv
// tb/tb_hamming_secded_codec.sv - directed table and sequence bench for hamming_secded_codec
module tb_hamming_secded_codec;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [2:0]       out_syndrome;
  logic             out_err_single;
  logic             out_err_double;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_corrected;
  logic [CNT_W-1:0] cnt_uncorrectable;

  hamming_secded_codec #(.DATA_W(4), .SECDED(1), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .mode              (mode),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_syndrome      (out_syndrome),
    .out_err_single    (out_err_single),
    .out_err_double    (out_err_double),
    .cnt_clr           (cnt_clr),
    .cnt_corrected     (cnt_corrected),
    .cnt_uncorrectable (cnt_uncorrectable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [7:0] din;
    logic [7:0] dout;
    logic [2:0] syn;
    logic       single;
    logic       double_e;
  } vec_t;

  vec_t vecs[13];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] ref_enc(input logic [3:0] d);
    logic p1, p2, p4;
    logic [6:0] c;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    c  = {d[3], d[2], d[1], p4, d[0], p2, p1};
    return {^c, c};
  endfunction

  // Result packed as {data[7:0], syndrome[2:0], single, double}.
  function automatic logic [12:0] ref_dec(input logic [7:0] cw);
    logic [2:0] s;
    logic       perr, sg, db;
    logic [7:0] c;
    s[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    s[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    s[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    perr = ^cw;
    c  = cw;
    sg = 1'b0;
    db = 1'b0;
    if (s != 3'd0 && perr) begin
      c[s-1] = ~c[s-1];
      sg = 1'b1;
    end else if (perr) sg = 1'b1;
    else if (s != 3'd0) db = 1'b1;
    return {4'h0, c[6], c[5], c[4], c[2], s, sg, db};
  endfunction

  function automatic logic [7:0] stream_word(input int i);
    logic [7:0] cw;
    if (i % 2 == 0) return 8'((i * 3) & 15);
    cw = ref_enc(4'(i));
    if (i % 4 == 1) cw = cw ^ (8'h01 << (i % 8));
    else            cw = cw ^ (8'h03 << (i % 7));
    return cw;
  endfunction

  function automatic logic [12:0] stream_exp(input int i);
    if (i % 2 == 0) return {ref_enc(4'((i * 3) & 15)), 5'b0};
    return ref_dec(stream_word(i));
  endfunction

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    mode = v.mode; in_data = v.din; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_lat1_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"}, 32'(out_data), 32'(v.dout));
    check({name, "_flags"}, {27'd0, out_syndrome, out_err_single, out_err_double},
          {27'd0, v.syn, v.single, v.double_e});
  endtask

  task automatic pulse_clr();
    @(negedge clk); cnt_clr = 1'b1;
    @(posedge clk); #1; cnt_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [12:0] q[$];
    logic [12:0] actv, held, expv;
    logic stalled, acc_in, acc_out;
    int sent, got, ok, exp_s, exp_d;

    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    vecs[0]  = '{1'b0, 8'h0B, 8'h55, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'hFF, 8'hFF, 3'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h01, 8'h87, 3'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h45, 8'h0B, 3'd5, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 8'hD5, 8'h0B, 3'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 8'h56, 8'h0B, 3'd3, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 8'h55, 8'h0B, 3'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h54, 8'h0B, 3'd1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 8'hFF, 8'h0F, 3'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h7F, 8'h0F, 3'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 8'hFC, 8'h0F, 3'd3, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 8'h07, 8'h01, 3'd0, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_counters", {24'd0, cnt_corrected, cnt_uncorrectable}, 32'd0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);

    exp_s = 0; exp_d = 0;
    foreach (vecs[i]) begin
      apply(vecs[i], $sformatf("vec%0d", i));
      exp_s += int'(vecs[i].single);
      exp_d += int'(vecs[i].double_e);
    end
    @(posedge clk); #1;
    check("table_cnt_corrected", 32'(cnt_corrected), 32'(exp_s));
    check("table_cnt_uncorrectable", 32'(cnt_uncorrectable), 32'(exp_d));

    pulse_clr();
    check("clr_counters", {24'd0, cnt_corrected, cnt_uncorrectable}, 32'd0);
    apply(vecs[4], "dec45");
    @(posedge clk); #1;
    check("dec45_cnt_corrected", 32'(cnt_corrected), 32'd1);
    apply(vecs[6], "dec56");
    @(posedge clk); #1;
    check("dec56_cnt_uncorrectable", 32'(cnt_uncorrectable), 32'd1);

    sent = 0; got = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 16) begin
        in_valid = 1'b1; mode = 1'(sent % 2); in_data = stream_word(sent);
      end else in_valid = 1'b0;
      #1;
      actv = {out_data, out_syndrome, out_err_single, out_err_double};
      if (stalled) check("stream_hold", {19'd0, out_valid, actv}, {19'd0, 1'b1, held});
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        if (q.size() > 0) begin
          expv = q.pop_front();
          check($sformatf("stream_word%0d", got), 32'(actv), 32'(expv));
        end else check("stream_extra_word", 32'(got), 32'd16);
        got++;
      end
      stalled = out_valid && !out_ready;
      held = actv;
      @(posedge clk);
      if (acc_in) begin
        q.push_back(stream_exp(sent));
        sent++;
      end
    end
    in_valid = 1'b0;
    check("stream_received", 32'(got), 32'd16);
    check("stream_queue_empty", 32'(q.size()), 32'd0);

    out_ready = 1'b0;
    @(negedge clk); mode = 1'b1; in_data = 8'h45; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_pre_valid", 32'(out_valid), 32'd1);
    @(negedge clk); rst = 1'b1; in_valid = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_outputs", {21'd0, out_data, out_syndrome, out_err_single, out_err_double}, 32'd0);
    check("midrst_counters", {24'd0, cnt_corrected, cnt_uncorrectable}, 32'd0);
    @(negedge clk); in_valid = 1'b0; rst = 1'b0; out_ready = 1'b1;
    #1;
    check("midrst_release_in_ready", 32'(in_ready), 32'd1);
    ok = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid) ok++;
    end
    check("midrst_no_stale_word", 32'(ok), 32'd0);

    ok = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      mode = 1'b1; in_data = 8'h45; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      if (in_ready) ok++;
      @(posedge clk);
    end
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("burst_in_ready_cycles", 32'(ok), 32'd17);
    check("sat_cnt_corrected", 32'(cnt_corrected), 32'hF);
    check("sat_cnt_uncorrectable", 32'(cnt_uncorrectable), 32'd0);

    @(negedge clk); mode = 1'b1; in_data = 8'h45; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("clrprio_out_valid", 32'(out_valid), 32'd1);
    cnt_clr = 1'b1;
    @(posedge clk); #1; cnt_clr = 1'b0;
    check("clrprio_cnt_corrected", 32'(cnt_corrected), 32'd0);
    @(posedge clk); #1;
    check("clrprio_cnt_after", 32'(cnt_corrected), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hamming_secded_codec.md
HAMMING_SECDED_CODEC -- requirements
Module: hamming_secded_codec

Interface
REQ-001 Parameter DATA_W, default 4: payload width, 1..57.
REQ-002 Parameter SECDED, default 1: 1 appends an overall-parity bit (SEC-DED), 0 gives plain SEC Hamming.
REQ-003 Parameter CNT_W, default 16: width of the error counters.
REQ-004 Derived constant P: smallest P with 2^P >= DATA_W+P+1.
REQ-005 Derived constant N = DATA_W+P. Derived constant CW = N+SECDED.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 mode  in  1  0 = encode, 1 = decode; sampled with in_valid.
REQ-009 in_valid  in  1; in_ready  out  1  input handshake.
REQ-010 in_data  in  CW  encode: payload in [DATA_W-1:0], upper bits ignored; decode: codeword.
REQ-011 out_valid  out  1; out_ready  in  1  output handshake.
REQ-012 out_data  out  CW  encode: codeword; decode: corrected payload in [DATA_W-1:0], upper bits 0.
REQ-013 out_syndrome  out  P  decode syndrome; 0 in encode mode.
REQ-014 out_err_single / out_err_double  out  1 each  decode error flags; 0 in encode mode.
REQ-015 cnt_clr  in  1  synchronous clear of both counters.
REQ-016 cnt_corrected / cnt_uncorrectable  out  CNT_W each  running error counts.

Function
REQ-017 Codeword layout: positions 1..N, with codeword bit index = position-1.
REQ-018 Parity bit p(2^k) sits at position 2^k. Payload bits fill the remaining positions in ascending order, d0 lowest.
REQ-019 p(2^k) = XOR of all positions whose index has bit k set. With SECDED=1, bit CW-1 = XOR of bits [N-1:0].
REQ-020 Two-stage pipeline. Stage 1 registers the input, mode and syndrome/parity terms. Stage 2 registers the corrected or encoded result and the flags.
REQ-021 Latency: 2 cycles from an in_valid&&in_ready edge to out_valid, when out_ready is held high.
REQ-022 Throughput: 1 word per cycle under continuous valid/ready.
REQ-023 A stage advances when it is empty or its downstream stage accepts; in_ready = !s1_full || s1_advances. The ready path is combinational.
REQ-024 out_data and all flags stay stable while out_valid && !out_ready. No word is lost or duplicated.
REQ-025 Syndrome = XOR of the positions of all set bits in codeword positions 1..N.
REQ-026 SECDED=1 decode outcomes (perr = overall parity mismatch):
- syndrome=0, perr=0: clean.
- syndrome!=0, perr=1: flip the bit at position syndrome; single.
- syndrome=0, perr=1: overall-parity bit in error; single; payload unchanged.
- syndrome!=0, perr=0: double; payload passed uncorrected.
REQ-027 SECDED=0 decode: syndrome!=0 flips the bit at that position and flags single.
REQ-028 A syndrome greater than N (shortened code) flags double and applies no correction, in both SECDED modes.
REQ-029 out_err_single and out_err_double are never both 1.
REQ-030 Counters increment once per accepted output (out_valid && out_ready) carrying the matching flag.
REQ-031 Counters saturate at all-ones.
REQ-032 cnt_clr has priority over a same-cycle increment.
REQ-033 Mode may change on every word. Each word is processed in the mode sampled with it.

Reset
REQ-034 rst asserted: both pipeline stages empty, out_valid=0, out_data=0, flags=0, out_syndrome=0, counters=0.
REQ-035 In-flight words are discarded. No partial word is presented after release.
REQ-036 in_ready=0 while rst is asserted. in_ready=1 in the first cycle after release.

Structure
REQ-037 A shared package hamming_pkg holds the P/N/CW derivation functions and a position-is-power-of-two function, for reuse by other codec blocks.
REQ-038 One sub-module, hamming_syndrome: combinational parity/syndrome generator over CW bits, instantiated once in stage 1 and reused for encode parity.

Verification (DATA_W=4, SECDED=1, CW=8)
REQ-039 Encode 0xB -> out_data 0x55, two cycles later.
REQ-040 Decode 0x45 (bit 4 flipped) -> data 0xB, syndrome 5, single=1, cnt_corrected=1.
REQ-041 Decode 0xD5 (bit 7 flipped) -> data 0xB, syndrome 0, single=1.
REQ-042 Decode 0x56 (bits 0 and 1 flipped) -> syndrome 3, double=1, cnt_uncorrectable=1.
REQ-043 Stream of 16 alternating encode/decode words with random out_ready stalls -> every output in order and correct, none dropped or duplicated.
REQ-044 Reset mid-stream -> out_valid=0 immediately, counters 0.
REQ-045 Preload a counter to all-ones, then an error word -> counter holds all-ones.
REQ-046 cnt_clr in the same cycle as an increment -> counter reads 0.
